// File: rtl/ir_seq_gen_if.sv
// Handshake and sensor-output bundle for the IR beam-break sequence emulator.
// master = stimulus side (self-test controller), slave = the emulator.
interface ir_seq_gen_if;
  logic start;
  logic dir_in;
  logic abort;
  logic busy;
  logic done;
  logic IR1;
  logic IR2;
  logic IR3;

  modport master (
    output start, dir_in, abort,
    input  busy, done, IR1, IR2, IR3
  );

  modport slave (
    input  start, dir_in, abort,
    output busy, done, IR1, IR2, IR3
  );
endinterface

// File: rtl/ir_seq_gen.sv
// IR beam-break emulator: on start, drives three staggered active-low pulses on
// IR1..IR3 (forward or reverse order) so the direction detector can be self-tested.
module ir_seq_gen #(
  parameter int PULSE_W = 13,
  parameter int LEAD    = 1,
  parameter int GAP1    = 3,
  parameter int GAP2    = 4,
  parameter int CW      = 8
) (
  input logic          CLK,
  input logic          RSTn,
  ir_seq_gen_if.slave  bus
);

  localparam int END_N = LEAD + GAP1 + GAP2 + PULSE_W;

  localparam logic [CW-1:0] F1_C   = CW'(LEAD);
  localparam logic [CW-1:0] F2_C   = CW'(LEAD + GAP1);
  localparam logic [CW-1:0] F3_C   = CW'(LEAD + GAP1 + GAP2);
  localparam logic [CW-1:0] E1_C   = CW'(LEAD + PULSE_W);
  localparam logic [CW-1:0] E2_C   = CW'(LEAD + GAP1 + PULSE_W);
  localparam logic [CW-1:0] END_C  = CW'(END_N);
  localparam logic [CW-1:0] MAX_C  = {CW{1'b1}};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Catch parameter sets whose end offset cannot be represented in the timebase.
  if ((END_N > (2 ** CW) - 1) || (PULSE_W < 1) || (LEAD < 1) || (GAP1 < 1) || (GAP2 < 1))
  begin : g_bad_params
    $error("ir_seq_gen: illegal parameters (CW=%0d too small for end offset %0d, or zero gap/width)",
           CW, END_N);
  end

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          dir_q,   dir_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic [2:0]    ir_q,    ir_d;     // bit0 = IR1, bit2 = IR3

  logic [CW-1:0] cnt_inc;
  logic          win1, win2, win3;

  // cnt_inc is the edge offset n that the upcoming edge represents.
  assign cnt_inc = (cnt_q == MAX_C) ? cnt_q : cnt_q + CW'(1);

  assign win1 = (cnt_inc >= F1_C) && (cnt_inc < E1_C);
  assign win2 = (cnt_inc >= F2_C) && (cnt_inc < E2_C);
  assign win3 = (cnt_inc >= F3_C) && (cnt_inc < END_C);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ir_d    = 3'b111;

    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort; abort alone is meaningless here.
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          dir_d   = bus.dir_in;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == END_C) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (dir_q) begin
            ir_d = ~{win3, win2, win1};
          end else begin
            ir_d = ~{win1, win2, win3};
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ir_q    <= 3'b111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.IR1  = ir_q[0];
  assign bus.IR2  = ir_q[1];
  assign bus.IR3  = ir_q[2];

endmodule

// File: tb/tb_ir_seq_gen.sv
// Directed bench for ir_seq_gen with default parameters: forward, reverse,
// ignored restart, abort, back-to-back and mid-sequence reset scenarios.
module tb_ir_seq_gen;

  logic CLK;
  logic RSTn;

  int tests_run;
  int tests_failed;

  ir_seq_gen_if bus_if ();

  ir_seq_gen #(
    .PULSE_W (13),
    .LEAD    (1),
    .GAP1    (3),
    .GAP2    (4),
    .CW      (8)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus_if)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (run_count=%0d)", tests_run);
    $fatal(1, "watchdog expired");
  end

  // Expected {IR3,IR2,IR1,busy,done} at offset k after the start edge E0.
  // Windows from the default timing: first fall 1..13, second 4..16, third 8..20.
  function automatic logic [4:0] exp_vec(input bit fwd, input int k);
    logic l1, l2, l3, ir1, ir2, ir3, bsy, dn;
    l1  = (k >= 1) && (k <= 13);
    l2  = (k >= 4) && (k <= 16);
    l3  = (k >= 8) && (k <= 20);
    ir1 = fwd ? ~l1 : ~l3;
    ir2 = ~l2;
    ir3 = fwd ? ~l3 : ~l1;
    bsy = (k >= 0) && (k <= 20);
    dn  = (k == 21);
    return {ir3, ir2, ir1, bsy, dn};
  endfunction

  function automatic logic [4:0] obs_vec();
    return {bus_if.IR3, bus_if.IR2, bus_if.IR1, bus_if.busy, bus_if.done};
  endfunction

  task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed {IR3,IR2,IR1,busy,done}=%b expected %b", tag, observed, expected);
    end
  endtask

  // One active edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Launch a sequence at E0 and check offsets 0..last_k.
  // poke_at: offset whose edge also sees start=1 with inverted dir_in (-1 = none).
  // abort_at: offset whose edge sees abort=1 (-1 = none); from there on all idle.
  // abort_at_start: abort held high together with start at E0.
  task automatic run_seq(input string name, input bit fwd, input int last_k,
                         input int poke_at, input int abort_at, input bit abort_at_start);
    logic [4:0] exp;
    bus_if.start  = 1'b1;
    bus_if.dir_in = fwd;
    bus_if.abort  = abort_at_start;
    tick();
    bus_if.start  = 1'b0;
    bus_if.abort  = 1'b0;
    bus_if.dir_in = ~fwd;
    check($sformatf("%s k=0", name), obs_vec(), exp_vec(fwd, 0));
    for (int k = 1; k <= last_k; k++) begin
      if (k == poke_at) begin
        bus_if.start  = 1'b1;
        bus_if.dir_in = ~fwd;
      end
      if (k == abort_at) bus_if.abort = 1'b1;
      tick();
      bus_if.start = 1'b0;
      bus_if.abort = 1'b0;
      if (abort_at >= 0 && k >= abort_at) exp = 5'b11100;
      else                                exp = exp_vec(fwd, k);
      check($sformatf("%s k=%0d", name, k), obs_vec(), exp);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    RSTn          = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.dir_in = 1'b0;
    bus_if.abort  = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset_hold", obs_vec(), 5'b11100);
    RSTn = 1'b1;
    tick();
    check("idle_after_reset", obs_vec(), 5'b11100);

    // abort alone in IDLE does nothing
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    check("abort_in_idle", obs_vec(), 5'b11100);

    // Forward and reverse full sequences, including a trailing idle cycle
    run_seq("fwd", 1'b1, 23, -1, -1, 1'b0);
    run_seq("rev", 1'b0, 23, -1, -1, 1'b0);

    // start with toggled dir_in at E0+5 is ignored; single done, nothing afterwards
    run_seq("restart_ignored", 1'b1, 30, 5, -1, 1'b0);

    // abort at E0+10, then a fresh start at the very next edge (abort also high: start wins)
    run_seq("abort", 1'b1, 10, -1, 10, 1'b0);
    run_seq("after_abort", 1'b1, 22, -1, -1, 1'b1);

    // Back-to-back with start held continuously
    bus_if.start  = 1'b1;
    bus_if.dir_in = 1'b1;
    tick();
    check("b2b k=0", obs_vec(), exp_vec(1'b1, 0));
    for (int k = 1; k <= 43; k++) begin
      tick();
      check($sformatf("b2b k=%0d", k), obs_vec(), exp_vec(1'b1, (k >= 22) ? k - 22 : k));
    end
    bus_if.start = 1'b0;
    tick();
    check("b2b k=44", obs_vec(), 5'b11100);

    // Reset asserted mid-sequence (between E0+5 and E0+6) acts immediately
    run_seq("pre_reset", 1'b1, 5, -1, -1, 1'b0);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("async_reset", obs_vec(), 5'b11100);
    tick();
    check("reset_held", obs_vec(), 5'b11100);
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    check("post_reset_idle", obs_vec(), 5'b11100);
    run_seq("post_reset_fwd", 1'b1, 22, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
